uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive path. Consumes the 16x-oversampling strobe from the baud rate generator
//  (rxclk_en) and the raw rx pin. Resynchronises the pin, detects the start bit and samples
//  each bit at mid-bit. Delivers each received byte as a one-cycle valid pulse to the UART
//  register/FIFO stage. Line format: 1 start, DATA_BITS data (LSB first), optional parity, 1 stop.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, legal range 5..8; data_o upper bits are zero when <8
//  SYNC_STAGES  2   flip-flop stages on uart_rx_i, legal range >=2
//  PARITY_ODD   0   used only with UART_RX_PARITY_EN; 0 = even parity, 1 = odd parity
// PORTS
//  clk_50m_i      in   1  system clock
//  rst_n_i        in   1  asynchronous reset, active low
//  rxclk_en_i     in   1  16x-baud strobe, one clk cycle wide
//  uart_rx_i      in   1  raw serial input, asynchronous, idle high
//  data_o         out  8  last good byte; held until the next good frame
//  data_valid_o   out  1  one-cycle pulse: data_o updated this cycle
//  frame_err_o    out  1  one-cycle pulse: stop bit sampled low
//  parity_err_o   out  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//  busy_o         out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0. Synchronizer chain is set to 1 (line idle). State = IDLE. tick_cnt = 0. bit_idx = 0.
//  - rx_s is the SYNC_STAGES-synchronised pin. State updates happen only in cycles where rxclk_en_i=1.
//    The only exception is the output pulses, which are each exactly one clk wide.
//  - tick_cnt is 4 bits and increments on each strobe; it wraps 15->0 and is cleared on every state entry.
//  - IDLE: when rx_s=0 on a strobe, go to START with tick_cnt=0.
//  - START: on the strobe where tick_cnt==7 (mid start bit):
//      rx_s=1 -> glitch, return to IDLE with no output.
//      rx_s=0 -> go to DATA with tick_cnt=0 and bit_idx=0.
//  - DATA: on the strobe where tick_cnt==15 (16 ticks later, i.e. mid-bit), shift rx_s into the
//    shift register LSB-first and increment bit_idx. After bit DATA_BITS-1, go to PARITY
//    (if UART_RX_PARITY_EN) or else STOP.
//  - STOP: on the strobe where tick_cnt==15, sample rx_s:
//      rx_s=1 -> if no parity error, update data_o and pulse data_valid_o in the next clk.
//                Then go to IDLE.
//      rx_s=0 -> pulse frame_err_o, leave data_o unchanged, go to BREAK.
//  - BREAK: wait for a strobe with rx_s=1, then go to IDLE. This prevents a held-low line from
//    being seen as back-to-back start bits.
//  - Latency: data_valid_o is high one clk after the stop-bit mid-sample strobe.
//  - If rxclk_en_i is held 0, the FSM freezes; no timeout.
//  - Reset mid-frame aborts the frame with no pulse; the FSM restarts in IDLE.
//  - A new start edge is accepted from the first strobe after returning to IDLE. The half stop bit
//    remaining after the mid-stop sample is never required.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY state is inserted after DATA; rx_s is sampled at tick_cnt==15.
//    - Expected parity = XOR of the data bits, inverted when PARITY_ODD=1.
//    - On a mismatch, parity_err_o pulses together with the stop-bit outcome, and data_valid_o is
//      suppressed. frame_err_o may pulse in the same cycle.
//  UART_RX_PARITY_EN undefined:
//    - No PARITY state; parity_err_o is constant 0; PARITY_ODD is ignored.
// TESTING (bench drives rxclk_en_i every 4 clks; one bit = 16 strobes; DATA_BITS=8)
//  1 Reset mid-frame: assert reset during bit 3 of 0x55, then send 0xAA
//    -> no pulse for 0x55; data_o=0xAA with one valid pulse.
//  2 Send 0xA5 with stop=1
//    -> data_o=0xA5, data_valid_o high for exactly 1 clk, 1 clk after the stop mid-sample.
//       frame_err_o=0, busy_o low afterwards.
//  3 Low glitch 5 strobes long on an idle line
//    -> return to IDLE at tick 7; no pulses; next frame 0x3C is received correctly.
//  4 Send 0x0F with the stop bit held low, then the line stays low 40 strobes, then goes high;
//    then send 0x81
//    -> one frame_err_o pulse, data_o keeps its previous value, no further pulses while the line
//       is low, then 0x81 is received.
//  5 Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap
//    -> three valid pulses in order; data_o=0x5A at the end.
//  6 UART_RX_PARITY_EN with PARITY_ODD=0: 0x07 sent with parity bit 1, then 0x07 with parity bit 0
//    -> first frame: data_valid_o pulse; second frame: parity_err_o pulse, no data_valid_o,
//       data_o stays 0x07.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver (start, DATA_BITS data LSB first, optional parity, stop)
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Ports:
//   clk_50m_i    system clock
//   rst_n_i      asynchronous active-low reset
//   rxclk_en_i   16x-baud strobe, one clk wide
//   uart_rx_i    raw asynchronous serial input, idle high
//   data_o       last good byte, zero-extended when DATA_BITS < 8
//   data_valid_o one-clk pulse when data_o updates
//   frame_err_o  one-clk pulse when the stop bit is sampled low
//   parity_err_o one-clk pulse on parity mismatch (constant 0 without parity)
//   busy_o       high whenever the receiver is not idle
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk_50m_i,
  input  logic       rst_n_i,
  input  logic       rxclk_en_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);
`ifdef UART_RX_PARITY_EN
  localparam bit P_EN = 1'b1;
`else
  localparam bit P_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_tick, w_tick_n;
  logic [2:0]             r_bit_idx, w_idx_n;
  logic [7:0]             r_shift, w_shift_n, r_data, w_data_n, w_data;
  logic                   r_pbad, w_pbad_n, r_valid, w_valid_n, r_ferr, w_ferr_n, r_perr, w_perr_n;
  logic                   w_rx;
  assign w_rx = r_sync[SYNC_STAGES-1];
  // bits enter at the MSB, so the received word sits in the top DATA_BITS bits
  assign w_data = r_shift >> (8 - DATA_BITS);
  always_ff @(posedge clk_50m_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= S_IDLE;
    else r_state <= w_state_n;
  always_ff @(posedge clk_50m_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_sync    <= '1;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_pbad    <= 1'b0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
      r_tick    <= w_tick_n;
      r_bit_idx <= w_idx_n;
      r_shift   <= w_shift_n;
      r_data    <= w_data_n;
      r_pbad    <= w_pbad_n;
      r_valid   <= w_valid_n;
      r_ferr    <= w_ferr_n;
      r_perr    <= w_perr_n;
    end
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_idx_n   = r_bit_idx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_pbad_n  = r_pbad;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    w_perr_n  = 1'b0;
    if (rxclk_en_i) begin
      w_tick_n = r_tick + 4'd1;
      case (r_state)
        S_IDLE:
          if (!w_rx) begin
            w_state_n = S_START;
            w_tick_n  = '0;
          end
        S_START:
          if (r_tick == 4'd7) begin
            w_state_n = w_rx ? S_IDLE : S_DATA;
            w_tick_n  = '0;
            w_idx_n   = '0;
          end
        S_DATA:
          if (r_tick == 4'd15) begin
            w_shift_n = {w_rx, r_shift[7:1]};
            w_idx_n   = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) w_state_n = P_EN ? S_PARITY : S_STOP;
          end
        S_PARITY:
          if (r_tick == 4'd15) begin
            w_pbad_n  = w_rx ^ (^w_data) ^ PARITY_ODD;
            w_state_n = S_STOP;
          end
        S_STOP:
          if (r_tick == 4'd15) begin
            w_perr_n  = P_EN & r_pbad;
            w_valid_n = w_rx & ~(P_EN & r_pbad);
            w_data_n  = (w_rx && !(P_EN && r_pbad)) ? w_data : r_data;
            w_ferr_n  = ~w_rx;
            w_state_n = w_rx ? S_IDLE : S_BREAK;
          end
        S_BREAK:
          if (w_rx) begin
            w_state_n = S_IDLE;
            w_tick_n  = '0;
          end
        default: w_state_n = S_IDLE;
      endcase
    end
  end
  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign frame_err_o  = r_ferr;
  assign parity_err_o = P_EN ? r_perr : 1'b0;
  assign busy_o       = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core (strobe every 4 clks, 64 clks per bit)
module tb_uart_rx_core;
  logic       clk = 1'b0, rst_n = 1'b0, rxclk_en = 1'b0, rx = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr, busy;
  int         checks = 0, failures = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  logic [7:0] hist [16];
  uart_rx_core dut (
    .clk_50m_i(clk), .rst_n_i(rst_n), .rxclk_en_i(rxclk_en), .uart_rx_i(rx),
    .data_o(data), .data_valid_o(valid), .frame_err_o(ferr), .parity_err_o(perr), .busy_o(busy)
  );
  always #5 clk = ~clk;
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      rxclk_en = 1'b1;
      @(negedge clk);
      rxclk_en = 1'b0;
    end
  end
  always @(negedge clk)
    if (rst_n) begin
      if (valid) begin
        if (n_valid < 16) hist[n_valid] = data;
        n_valid = n_valid + 1;
      end
      if (ferr) n_ferr = n_ferr + 1;
      if (perr) n_perr = n_perr + 1;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(64);
  endtask
  task automatic send_body(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b0;
`endif
  endtask
  task automatic send_frame(input logic [7:0] d);
    send_body(d, ^d);
    send_bit(1'b1);
  endtask
  initial begin
    wait_clk(10);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_perr", perr, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(40);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1 ^ i[0]);
    rx = 1'b1;
    wait_clk(30);
    check("t1_busy_midframe", busy, 1'b1);
    rst_n = 1'b0;
    wait_clk(5);
    check("t1_busy_in_reset", busy, 1'b0);
    check("t1_data_in_reset", data, 8'h00);
    rst_n = 1'b1;
    wait_clk(100);
    check("t1_no_pulse_0x55", n_valid, 0);
    send_frame(8'hAA);
    wait_clk(40);
    check("t1_valid_count", n_valid, 1);
    check("t1_data", data, 8'hAA);
    check("t1_pulse_data", hist[0], 8'hAA);
    send_body(8'hA5, 1'b0);
    rx = 1'b1;
    wait_clk(16);
    check("t2_not_early", n_valid, 1);
    wait_clk(48);
    check("t2_valid_once", n_valid, 2);
    check("t2_data", data, 8'hA5);
    check("t2_pulse_data", hist[1], 8'hA5);
    check("t2_ferr", n_ferr, 0);
    check("t2_busy_after", busy, 1'b0);
    wait_clk(40);
    rx = 1'b0;
    wait_clk(12);
    check("t3_busy_glitch", busy, 1'b1);
    wait_clk(8);
    rx = 1'b1;
    wait_clk(60);
    check("t3_idle_after_glitch", busy, 1'b0);
    check("t3_no_valid", n_valid, 2);
    check("t3_no_ferr", n_ferr, 0);
    send_frame(8'h3C);
    wait_clk(40);
    check("t3_valid_count", n_valid, 3);
    check("t3_data", data, 8'h3C);
    send_body(8'h0F, 1'b0);
    rx = 1'b0;
    wait_clk(64);
    check("t4_ferr_once", n_ferr, 1);
    wait_clk(160);
    check("t4_ferr_still_once", n_ferr, 1);
    check("t4_no_valid", n_valid, 3);
    check("t4_data_kept", data, 8'h3C);
    check("t4_busy_break", busy, 1'b1);
    rx = 1'b1;
    wait_clk(40);
    check("t4_idle", busy, 1'b0);
    send_frame(8'h81);
    wait_clk(40);
    check("t4_valid_count", n_valid, 4);
    check("t4_data", data, 8'h81);
    check("t4_ferr_total", n_ferr, 1);
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'h5A);
    wait_clk(40);
    check("t5_valid_count", n_valid, 7);
    check("t5_first", hist[4], 8'h00);
    check("t5_second", hist[5], 8'hFF);
    check("t5_third", hist[6], 8'h5A);
    check("t5_data", data, 8'h5A);
    check("t5_ferr_total", n_ferr, 1);
    check("t5_perr_total", n_perr, 0);
`ifdef UART_RX_PARITY_EN
    send_body(8'h07, 1'b1);
    send_bit(1'b1);
    wait_clk(40);
    check("t6_good_valid", n_valid, 8);
    check("t6_good_data", data, 8'h07);
    check("t6_good_perr", n_perr, 0);
    send_body(8'h07, 1'b0);
    send_bit(1'b1);
    wait_clk(40);
    check("t6_bad_no_valid", n_valid, 8);
    check("t6_bad_perr", n_perr, 1);
    check("t6_bad_data_kept", data, 8'h07);
    check("t6_bad_ferr", n_ferr, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
